// File: rtl/dw02_mult_3_stage_pkg.sv
// ---------------------------------------------------------------------------
// dw02_mult_3_stage_pkg
//
// Purpose : Width helpers shared by the pipelined multiplier and its
//           partial-product stage. Keeping the result width and the B split
//           point in one place guarantees the top level and the bench-visible
//           stage boundary agree on where B is cut.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package dw02_mult_3_stage_pkg;

  // Full product width: exact for both signed and unsigned operands.
  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Number of low-order B bits that form the (always unsigned) lo slice.
  // Floor division, so for odd B widths the hi slice is the larger one.
  function automatic int split_point(input int b_w);
    return b_w / 2;
  endfunction

endpackage : dw02_mult_3_stage_pkg

// File: rtl/dw02_mult_3_stage_partial.sv
// ---------------------------------------------------------------------------
// mult_partial_stage
//
// Purpose : Combinational partial product a * slice, where each operand is
//           independently treated as two's-complement or unsigned. The result
//           is exact in A_width+S_width bits for every signedness mix:
//             signed   x signed   : |p| <= 2^(A+S-2)
//             signed   x unsigned : |p| <  2^(A+S-1)
//             unsigned x unsigned : p   <  2^(A+S)
//           so extending both operands to the result width and keeping the
//           low bits of the product yields the exact value.
//
// Ports   :
//   a            in  A_width          multiplicand
//   slice        in  S_width          slice of the multiplier
//   a_signed     in  1                1 = a is two's-complement
//   slice_signed in  1                1 = slice is two's-complement
//   product      out A_width+S_width  a * slice (signed iff either is signed)
// ---------------------------------------------------------------------------
module mult_partial_stage #(
  parameter int A_width = 8,
  parameter int S_width = 4
) (
  input  logic [A_width-1:0]         a,
  input  logic [S_width-1:0]         slice,
  input  logic                       a_signed,
  input  logic                       slice_signed,
  output logic [A_width+S_width-1:0] product
);

  localparam int PW = A_width + S_width;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] slice_ext;

  // Sign- or zero-extend each operand to the result width; the modular
  // product of the extended values is then the exact mixed-sign product.
  assign a_ext     = {{S_width{a_signed & a[A_width-1]}}, a};
  assign slice_ext = {{A_width{slice_signed & slice[S_width-1]}}, slice};

  assign product = a_ext * slice_ext;

endmodule : mult_partial_stage

// File: rtl/dw02_mult_3_stage.sv
// ---------------------------------------------------------------------------
// dw02_mult_3_stage
//
// Purpose : Two-register pipelined multiplier (the third stage is the
//           caller's operand register). Accepts a new A/B/TC every cycle and
//           presents the full-width product two rising CLK edges later.
//           B is split at K = B_width/2:
//             stage 1 : P_lo = A * B_lo (B_lo unsigned),
//                       P_hi = A * B_hi (B_hi signed when TC = 1)
//             stage 2 : PRODUCT = (P_hi << K) + P_lo
//           TC travels with its partial products so mixed-TC streams are
//           handled per operand pair.
//
// Ports   :
//   CLK      in  1                 rising-edge clock
//   reset_n  in  1                 asynchronous active-low reset, clears all
//                                  pipeline registers
//   A        in  A_width           multiplicand
//   B        in  B_width           multiplier
//   TC       in  1                 1 = two's-complement, 0 = unsigned
//   PRODUCT  out A_width+B_width   registered product A * B
// ---------------------------------------------------------------------------
module dw02_mult_3_stage
  import dw02_mult_3_stage_pkg::*;
#(
  parameter int A_width = 8,
  parameter int B_width = 8
) (
  input  logic                                     CLK,
  input  logic                                     reset_n,
  input  logic [A_width-1:0]                       A,
  input  logic [B_width-1:0]                       B,
  input  logic                                     TC,
  output logic [prod_width(A_width, B_width)-1:0]  PRODUCT
);

  localparam int PW   = prod_width(A_width, B_width);
  localparam int K    = split_point(B_width);
  localparam int HB_W = B_width - K;      // width of B_hi
  localparam int LW   = A_width + K;      // width of P_lo
  localparam int HW   = A_width + HB_W;   // width of P_hi

  // -------------------------------------------------------------------------
  // Stage 1: partial products (combinational from the inputs)
  // -------------------------------------------------------------------------
  logic [LW-1:0] p_lo_next;
  logic [HW-1:0] p_hi_next;

  // Low slice is a plain magnitude in both modes; only A carries a sign.
  mult_partial_stage #(
    .A_width (A_width),
    .S_width (K)
  ) u_partial_lo (
    .a            (A),
    .slice        (B[K-1:0]),
    .a_signed     (TC),
    .slice_signed (1'b0),
    .product      (p_lo_next)
  );

  // High slice holds B's sign bit, so it is signed whenever B is.
  mult_partial_stage #(
    .A_width (A_width),
    .S_width (HB_W)
  ) u_partial_hi (
    .a            (A),
    .slice        (B[B_width-1:K]),
    .a_signed     (TC),
    .slice_signed (TC),
    .product      (p_hi_next)
  );

  logic [LW-1:0] p_lo_reg;
  logic [HW-1:0] p_hi_reg;
  logic          tc_reg;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      p_lo_reg <= '0;
      p_hi_reg <= '0;
      tc_reg   <= 1'b0;
    end else begin
      p_lo_reg <= p_lo_next;
      p_hi_reg <= p_hi_next;
      tc_reg   <= TC;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: recombine. Both partials are signed values when tc_reg = 1
  // (signed A times anything), so they are sign-extended to the full width
  // before the shifted add; in unsigned mode they are zero-extended.
  // -------------------------------------------------------------------------
  logic [PW-1:0] p_lo_ext;
  logic [PW-1:0] p_hi_ext;
  logic [PW-1:0] product_next;
  logic [PW-1:0] product_reg;

  always_comb begin
    p_lo_ext     = {{HB_W{tc_reg & p_lo_reg[LW-1]}}, p_lo_reg};
    p_hi_ext     = {{K{tc_reg & p_hi_reg[HW-1]}}, p_hi_reg};
    // Bits shifted out above PW are discarded; the true product fits in PW.
    product_next = (p_hi_ext << K) + p_lo_ext;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      product_reg <= '0;
    end else begin
      product_reg <= product_next;
    end
  end

  assign PRODUCT = product_reg;

endmodule : dw02_mult_3_stage

// File: tb/tb_dw02_mult_3_stage.sv
// ---------------------------------------------------------------------------
// tb_dw02_mult_3_stage
//
// Scoreboard bench: the stimulus process pushes an expected product with the
// cycle in which it must appear; the monitor pops and compares on each
// falling edge. Reset bumps an epoch so in-flight expectations are dropped.
// Three DUTs: 20x20 (directed + random), 8x8 and 7x5 (random).
// ---------------------------------------------------------------------------
module tb_dw02_mult_3_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [19:0] a20, b20;
  logic        t20;
  logic [39:0] p20;
  logic [7:0]  a8, b8;
  logic        t8;
  logic [15:0] p8;
  logic [6:0]  a7;
  logic [4:0]  b5;
  logic        t7;
  logic [11:0] p7;

  dw02_mult_3_stage #(.A_width(20), .B_width(20)) dut20 (
    .CLK(clk), .reset_n(reset_n), .A(a20), .B(b20), .TC(t20), .PRODUCT(p20));
  dw02_mult_3_stage #(.A_width(8), .B_width(8)) dut8 (
    .CLK(clk), .reset_n(reset_n), .A(a8), .B(b8), .TC(t8), .PRODUCT(p8));
  dw02_mult_3_stage #(.A_width(7), .B_width(5)) dut75 (
    .CLK(clk), .reset_n(reset_n), .A(a7), .B(b5), .TC(t7), .PRODUCT(p7));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          epoch;
    int          id;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   epoch   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Exact reference multiply on sign/zero-extended operands.
  function automatic logic [63:0] ref_mult(input logic [63:0] a, input logic [63:0] b,
                                           input int aw, input int bw, input logic t);
    longint sa, sb;
    logic [63:0] m;
    sa = longint'(a & ((64'd1 << aw) - 64'd1));
    sb = longint'(b & ((64'd1 << bw) - 64'd1));
    if (t && a[aw-1]) sa = sa - (longint'(1) << aw);
    if (t && b[bw-1]) sb = sb - (longint'(1) << bw);
    m = 64'(sa * sb);
    return m & ((64'd1 << (aw + bw)) - 64'd1);
  endfunction

  task automatic expect_at(input int due, input int id, input logic [63:0] exp,
                           input string name);
    exp_t e;
    e.due   = due;
    e.epoch = epoch;
    e.id    = id;
    e.exp   = exp;
    e.name  = name;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair on the 20x20 DUT; result due two edges later.
  task automatic drive20(input logic [19:0] a, input logic [19:0] b, input logic t,
                         input logic [39:0] exp, input string name);
    a20 = a;
    b20 = b;
    t20 = t;
    expect_at(cyc + 2, 0, {24'b0, exp}, name);
    step();
  endtask

  // Monitor
  exp_t        cur;
  logic [63:0] got;
  always @(negedge clk) begin
    while (sbq.size() > 0 && (sbq[0].epoch != epoch || sbq[0].due <= cyc)) begin
      cur = sbq.pop_front();
      if (cur.epoch == epoch) begin
        case (cur.id)
          0:       got = {24'b0, p20};
          1:       got = {48'b0, p8};
          default: got = {52'b0, p7};
        endcase
        n_tests++;
        if (cur.due != cyc) begin
          n_fail++;
          $display("FAIL %s: result missed its cycle (due %0d, now %0d)", cur.name, cur.due, cyc);
        end else if (got !== cur.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, want %h (cycle %0d)", cur.name, got, cur.exp, cyc);
        end else begin
          $display("[TB] ok %s: %h (cycle %0d)", cur.name, got, cyc);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    a20 = 20'd7; b20 = 20'd9; t20 = 1'b0;
    a8 = '0; b8 = '0; t8 = 1'b0;
    a7 = '0; b5 = '0; t7 = 1'b0;

    // Reset held with operands present and clock running: output stays 0.
    step();
    for (int i = 0; i < 3; i++) begin
      expect_at(cyc, 0, 64'd0, "rst_hold");
      step();
    end

    // Release between edges: 0 after the first edge, 7*9 after the second.
    reset_n = 1'b1;
    expect_at(cyc + 1, 0, 64'd0, "rel_edge1");
    expect_at(cyc + 2, 0, 64'd63, "rel_edge2");
    step();

    // Directed vectors with hand-computed products
    drive20(20'd3,      20'hFFFFB, 1'b1, 40'hFFFFFFFFF1, "signed_3x-5");
    drive20(20'hFFFFF,  20'd1,     1'b1, 40'hFFFFFFFFFF, "tc1_-1x1");
    drive20(20'hFFFFF,  20'd1,     1'b0, 40'h00000FFFFF, "tc0_maxx1");
    drive20(20'h80000,  20'h80000, 1'b1, 40'h4000000000, "tc1_minxmin");
    drive20(20'h80000,  20'h80000, 1'b0, 40'h4000000000, "tc0_2^19x2^19");
    drive20(20'hFFFFF,  20'hFFFFF, 1'b0, 40'hFFFFE00001, "tc0_maxxmax");
    drive20(20'hFFFFF,  20'hFFFFF, 1'b1, 40'h0000000001, "tc1_-1x-1");
    drive20(20'h80000,  20'd1,     1'b1, 40'hFFFFF80000, "tc1_minx1");
    drive20(20'd0,      20'hFFFFF, 1'b1, 40'h0000000000, "zero");

    // Back-to-back stream; the last two are in flight when reset hits.
    for (int i = 1; i <= 18; i++)
      drive20(20'(i), 20'd100, 1'b0, 40'(100 * i), $sformatf("stream_%0d", i));

    // Asynchronous reset mid-cycle: output must clear before the next edge.
    #2;
    reset_n = 1'b0;
    epoch++;
    expect_at(cyc, 0, 64'd0, "async_rst");
    step();
    expect_at(cyc, 0, 64'd0, "rst_hold2");
    a20 = 20'd5; b20 = 20'd6; t20 = 1'b0;
    reset_n = 1'b1;
    expect_at(cyc + 1, 0, 64'd0, "no_stale");
    expect_at(cyc + 2, 0, 64'd30, "post_rst_5x6");
    step();
    drive20(20'd2, 20'hFFFFD, 1'b1, 40'hFFFFFFFFFA, "post_rst_2x-3");

    // Random vectors on all three widths against the reference multiply
    for (int n = 0; n < 10000; n++) begin
      a20 = 20'($urandom); b20 = 20'($urandom); t20 = 1'($urandom);
      a8  = 8'($urandom);  b8  = 8'($urandom);  t8  = 1'($urandom);
      a7  = 7'($urandom);  b5  = 5'($urandom);  t7  = 1'($urandom);
      expect_at(cyc + 2, 0, ref_mult(64'(a20), 64'(b20), 20, 20, t20), "rand20x20");
      expect_at(cyc + 2, 1, ref_mult(64'(a8),  64'(b8),  8,  8,  t8),  "rand8x8");
      expect_at(cyc + 2, 2, ref_mult(64'(a7),  64'(b5),  7,  5,  t7),  "rand7x5");
      step();
    end

    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dw02_mult_3_stage
